imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that writes instruction memory, the write-side counterpart of the fetch stage's byte-addressed, big-endian instruction memory read. Accepts 32-bit instruction words over a valid/ready stream and serializes each into four byte writes, most-significant byte first at increasing addresses. Holds the core frozen while loading, then pulses a core reset so fetch restarts at PC 0 on the new program.

## Interface
Parameters:
- MEM_BYTES, 256: instruction memory size in bytes. Power of two, multiple of 4.
- AW, 8: byte address width; log2(MEM_BYTES).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse; begins a load session when idle.
- load_valid  input  1  word available on load_data.
- load_data  input  32  instruction word.
- load_last  input  1  qualifies the final word of the session.
- load_ready  output  1  loader accepts a word this cycle.
- mem_we  output  1  byte write strobe.
- mem_addr  output  AW  byte address.
- mem_wdata  output  8  byte data.
- core_hold  output  1  freeze to fetch/pipeline; high for the whole session.
- core_rst  output  1  one-cycle pulse at session end.
- done  output  1  one-cycle pulse at session end, coincident with core_rst.
- error  output  1  sticky overflow flag; cleared by the next start or by rst.
- checksum  output  32  wrapping sum of accepted words.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE: load_ready=0, core_hold=0. When start=1: go to ACCEPT, base address=0, error=0, checksum=0.
- ACCEPT: load_ready=1, core_hold=1. When load_valid=1: capture load_data and load_last, go to WRITE, byte index=0.
- WRITE: load_ready=0, mem_we=1 for 4 cycles.
  - Byte k (0..3) writes load_data[31-8k:24-8k] to base+k.
  - After k=3, base += 4.
  - If the captured last=1, go to DONE.
  - Else if base wraps to 0 (memory full, MEM_BYTES/4 words written), set error=1 and go to DONE.
  - Else go to ACCEPT.
- DONE: done=1, core_rst=1, core_hold=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE.
- load_valid is ignored outside ACCEPT. No word is consumed unless load_valid and load_ready are both high.
- Address arithmetic is AW bits, modulo MEM_BYTES.

## Timing
- Reset values: state=IDLE. All outputs 0: load_ready, mem_we, mem_addr, mem_wdata, core_hold, core_rst, done, error, checksum.
- start is sampled at cycle t; load_ready=1 from t+1.
- A handshake at cycle t produces byte writes at t+1..t+4.
- Next load_ready=1 at t+5, so peak throughput is one word per 5 cycles.
- Last word handshake at t: done and core_rst high at t+5, IDLE with core_hold=0 at t+6.
- rst asserted mid-session: immediate return to IDLE with all outputs 0. Memory contents are partial and undefined. core_rst is not pulsed.
- A single-word session (load_last on the first word) is legal and ends after 6 cycles from start.

## Configuration
- LOADER_CHECKSUM_EN defined: checksum register accumulates each accepted word, 32-bit wrapping, updated on the handshake cycle, and holds its value after DONE until the next start.
- LOADER_CHECKSUM_EN undefined: no accumulator is built and checksum is tied to 0.

## Structure
- Shared package loader_pkg: state enum (IDLE, ACCEPT, WRITE, DONE), WORD_BYTES=4, default MEM_BYTES.
- One sub-module, word_serializer: takes a 32-bit word plus base address and emits 4 sequenced big-endian byte writes with a finish strobe. The top-level FSM sequences it.

## Test plan
- Reset mid-WRITE on byte 2 -> all outputs 0 next cycle; no core_rst; a following start begins at address 0.
- start, then word 0xE3A01005 with last=1 -> writes E3@0, A0@1, 10@2, 05@3 on consecutive cycles. done/core_rst pulse 5 cycles after the handshake; error=0.
- Three words with load_valid gaps and a stalled source -> writes to addresses 0..11 in order; load_ready low throughout each WRITE; no word lost or duplicated.
- 64 words with no last (MEM_BYTES=256) -> final write at address 255, error=1, done pulse, next mem_addr wraps to 0.
- start asserted during ACCEPT/WRITE -> ignored; base address and checksum not reset.
- With LOADER_CHECKSUM_EN: words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001. Without the macro -> checksum=0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
//   state_t           : loader FSM states (IDLE, ACCEPT, WRITE, DONE)
//   WORD_BYTES        : bytes per instruction word
//   BYTE_IDX_W        : width of the byte index within a word
//   DEFAULT_MEM_BYTES : default instruction memory size in bytes
package loader_pkg;

   localparam int unsigned WORD_BYTES        = 4;
   localparam int unsigned BYTE_IDX_W        = 2;
   localparam int unsigned DEFAULT_MEM_BYTES = 256;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/word_serializer.sv
// Splits one 32-bit word into four big-endian byte writes at base..base+3.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   go         : load word/base; byte 0 appears on the next cycle
//   word, base : word to write and its starting byte address
//   mem_we, mem_addr, mem_wdata : registered byte write port
//   finish_c   : high during the cycle that carries the last byte
module word_serializer
   import loader_pkg::*;
#(
   parameter int unsigned AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          go,
   input  logic [31:0]   word,
   input  logic [AW-1:0] base,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   output logic          finish_c
);

   logic [23:0]           rest;
   logic [BYTE_IDX_W-1:0] idx;

   assign finish_c = mem_we && (idx == BYTE_IDX_W'(WORD_BYTES - 1));

   // Shift register walks the word MSB first; address keeps counting so that
   // after the last byte it already points at the next word (wrapping mod 2^AW).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rest      <= '0;
         idx       <= '0;
      end else if (go) begin
         mem_we    <= 1'b1;
         mem_addr  <= base;
         mem_wdata <= word[31:24];
         rest      <= word[23:0];
         idx       <= '0;
      end else if (mem_we) begin
         mem_addr <= mem_addr + AW'(1);
         if (finish_c) begin
            mem_we <= 1'b0;
         end else begin
            mem_wdata <= rest[23:16];
            rest      <= {rest[15:0], 8'h00};
            idx       <= idx + BYTE_IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Program loader: accepts 32-bit words on a valid/ready stream and writes them
// big-endian into byte-addressed instruction memory from address 0, holding
// the core frozen during the session and pulsing core_rst at the end.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   start                             : begin a session (only honoured in IDLE)
//   load_valid, load_data, load_last  : input word stream
//   load_ready                        : word accepted when load_valid & load_ready
//   mem_we, mem_addr, mem_wdata       : byte write port
//   core_hold, core_rst, done         : core control / session-end pulse
//   error                             : sticky memory-overflow flag
//   checksum                          : wrapping sum of accepted words
// Build option: LOADER_CHECKSUM_EN builds the checksum accumulator; otherwise
// checksum is tied to 0.
module imem_loader
   import loader_pkg::*;
#(
   parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES,
   parameter int unsigned AW        = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          load_valid,
   input  logic [31:0]   load_data,
   input  logic          load_last,
   output logic          load_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   output logic          core_hold,
   output logic          core_rst,
   output logic          done,
   output logic          error,
   output logic [31:0]   checksum
);

   state_t        state;
   logic [AW-1:0] base;
   logic          last_q;
   logic          fire_c;
   logic          finish_c;
   logic          full_c;

   assign fire_c = load_ready && load_valid;
   // The word being written occupies the top slot, so base wraps to 0 next.
   assign full_c = (base == AW'(MEM_BYTES - WORD_BYTES));

   word_serializer #(.AW(AW)) u_ser (
      .clk       (clk),
      .rst       (rst),
      .go        (fire_c),
      .word      (load_data),
      .base      (base),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .finish_c  (finish_c)
   );

   // Session FSM with registered control outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         base       <= '0;
         last_q     <= 1'b0;
         load_ready <= 1'b0;
         core_hold  <= 1'b0;
         core_rst   <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         core_rst <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= ACCEPT;
                  base       <= '0;
                  error      <= 1'b0;
                  load_ready <= 1'b1;
                  core_hold  <= 1'b1;
               end
            end
            ACCEPT: begin
               if (load_valid) begin
                  state      <= WRITE;
                  last_q     <= load_last;
                  load_ready <= 1'b0;
               end
            end
            WRITE: begin
               if (finish_c) begin
                  base <= base + AW'(WORD_BYTES);
                  if (last_q || full_c) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     core_rst <= 1'b1;
                     if (!last_q) begin
                        error <= 1'b1;
                     end
                  end else begin
                     state      <= ACCEPT;
                     load_ready <= 1'b1;
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               core_hold <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [31:0] sum;

   // Cleared on session start, accumulates on each handshake, held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= '0;
      end else if ((state == IDLE) && start) begin
         sum <= '0;
      end else if (fire_c) begin
         sum <= sum + load_data;
      end
   end

   assign checksum = sum;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven per-cycle vectors for the
// single-word and stalled multi-word sessions, plus hand-written sequences for
// checksum, memory overflow and reset mid-write.
module tb_imem_loader;

   localparam int unsigned AW = 8;

`ifdef LOADER_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   // status = {load_ready, mem_we, core_hold, core_rst, done, error}
   localparam logic [5:0] S_IDLE = 6'b000000;
   localparam logic [5:0] S_ACC  = 6'b101000;
   localparam logic [5:0] S_WR   = 6'b011000;
   localparam logic [5:0] S_DONE = 6'b001110;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          load_valid;
   logic [31:0]   load_data;
   logic          load_last;
   logic          load_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          core_hold;
   logic          core_rst;
   logic          done;
   logic          error;
   logic [31:0]   checksum;

   int passed = 0;
   int total  = 0;

   imem_loader #(.MEM_BYTES(256), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .core_hold  (core_hold),
      .core_rst   (core_rst),
      .done       (done),
      .error      (error),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        valid;
      logic [31:0] data;
      logic        last;
      logic [5:0]  exp_st;
      logic [7:0]  exp_addr;
      logic [7:0]  exp_wdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic s, input logic v, input logic [31:0] d,
                               input logic l, input logic [5:0] st,
                               input logic [7:0] a, input logic [7:0] w);
      vec_t r;
      r.start = s; r.valid = v; r.data = d; r.last = l;
      r.exp_st = st; r.exp_addr = a; r.exp_wdata = w;
      return r;
   endfunction

   function automatic logic [5:0] status();
      return {load_ready, mem_we, core_hold, core_rst, done, error};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 20 && !load_ready; i++) tick();
      check("wait_ready", 64'(load_ready), 64'd1);
   endtask

   // Handshake one word, then check its four byte writes starting at a0.
   task automatic send_word(input logic [31:0] d, input logic l, input logic [7:0] a0);
      logic ok;
      logic [31:0] dv;
      wait_ready();
      load_valid = 1'b1; load_data = d; load_last = l;
      tick();
      load_valid = 1'b0; load_last = 1'b0; load_data = 32'h0;
      ok = 1'b1;
      dv = d;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         if (!mem_we || mem_addr !== 8'(a0 + 8'(k)) || mem_wdata !== dv[31 - 8*k -: 8]) ok = 1'b0;
      end
      check($sformatf("word_%08h_at_%0d", d, a0), 64'(ok), 64'd1);
   endtask

   initial begin
      logic [31:0] sum;
      logic [31:0] d;

      rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
      tick(); tick();
      check("reset_state", {26'd0, status(), mem_addr, mem_wdata, checksum}, 64'd0);
      rst = 1'b0;
      tick();

      // Single word E3A01005 with last
      vecs.push_back(mk(1, 0, 32'h0,        0, S_ACC,  8'd0, 8'h00));
      vecs.push_back(mk(0, 1, 32'hE3A01005, 1, S_WR,   8'd0, 8'hE3));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_WR,   8'd1, 8'hA0));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_WR,   8'd2, 8'h10));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_WR,   8'd3, 8'h05));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_DONE, 8'd0, 8'h00));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_IDLE, 8'd0, 8'h00));
      // Three words, gaps, stalled valid during WRITE, stray start pulses
      vecs.push_back(mk(1, 0, 32'h0,        0, S_ACC,  8'd0,  8'h00));
      vecs.push_back(mk(1, 0, 32'h0,        0, S_ACC,  8'd0,  8'h00));
      vecs.push_back(mk(0, 1, 32'h11223344, 0, S_WR,   8'd0,  8'h11));
      vecs.push_back(mk(1, 1, 32'hDEADBEEF, 0, S_WR,   8'd1,  8'h22));
      vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, S_WR,   8'd2,  8'h33));
      vecs.push_back(mk(1, 1, 32'hDEADBEEF, 1, S_WR,   8'd3,  8'h44));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_ACC,  8'd0,  8'h00));
      vecs.push_back(mk(1, 0, 32'h0,        0, S_ACC,  8'd0,  8'h00));
      vecs.push_back(mk(0, 1, 32'h55667788, 0, S_WR,   8'd4,  8'h55));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_WR,   8'd5,  8'h66));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_WR,   8'd6,  8'h77));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_WR,   8'd7,  8'h88));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_ACC,  8'd0,  8'h00));
      vecs.push_back(mk(0, 1, 32'h99AABBCC, 1, S_WR,   8'd8,  8'h99));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_WR,   8'd9,  8'hAA));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_WR,   8'd10, 8'hBB));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_WR,   8'd11, 8'hCC));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_DONE, 8'd0,  8'h00));
      vecs.push_back(mk(0, 0, 32'h0,        0, S_IDLE, 8'd0,  8'h00));

      foreach (vecs[i]) begin
         start = vecs[i].start; load_valid = vecs[i].valid;
         load_data = vecs[i].data; load_last = vecs[i].last;
         tick();
         check($sformatf("vec%0d_status", i), 64'(status()), 64'(vecs[i].exp_st));
         if (vecs[i].exp_st[4])
            check($sformatf("vec%0d_write", i), 64'({mem_addr, mem_wdata}),
                  64'({vecs[i].exp_addr, vecs[i].exp_wdata}));
      end
      start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
      check("checksum_three_words", 64'(checksum), CK_EN ? 64'h00336698 : 64'd0);

      // Checksum wrap: FFFFFFFF + 00000002 = 00000001
      start = 1'b1; tick(); start = 1'b0;
      send_word(32'hFFFFFFFF, 1'b0, 8'd0);
      send_word(32'h00000002, 1'b1, 8'd4);
      tick();
      check("ck_done", 64'(status()), 64'(S_DONE));
      check("ck_value", 64'(checksum), CK_EN ? 64'd1 : 64'd0);
      tick();
      check("ck_idle", 64'(status()), 64'(S_IDLE));
      check("ck_held", 64'(checksum), CK_EN ? 64'd1 : 64'd0);

      // 64 words, no last: fills memory, overflow error, address wraps
      start = 1'b1; tick(); start = 1'b0;
      sum = 32'h0;
      for (int w = 0; w < 64; w++) begin
         d = {8'(4*w), 8'(4*w + 1), 8'(4*w + 2), 8'(4*w + 3)};
         sum = sum + d;
         send_word(d, 1'b0, 8'(4*w));
      end
      check("ovf_last_addr", 64'(mem_addr), 64'd255);
      tick();
      check("ovf_done", 64'(status()), 64'(S_DONE | 6'b000001));
      check("ovf_addr_wrap", 64'(mem_addr), 64'd0);
      check("ovf_checksum", 64'(checksum), CK_EN ? 64'(sum) : 64'd0);
      tick();
      check("ovf_error_sticky", 64'(status()), 64'(6'b000001));
      start = 1'b1; tick(); start = 1'b0;
      check("error_cleared_on_start", 64'(status()), 64'(S_ACC));

      // Reset mid-WRITE on byte 2
      load_valid = 1'b1; load_data = 32'h01020304; load_last = 1'b1;
      tick();
      load_valid = 1'b0; load_last = 1'b0; load_data = '0;
      tick(); tick();
      check("pre_rst_byte2", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, 8'd2, 8'h03}));
      rst = 1'b1;
      #1;
      check("rst_async_zero", {26'd0, status(), mem_addr, mem_wdata, checksum}, 64'd0);
      tick();
      check("rst_no_core_rst", {26'd0, status(), mem_addr, mem_wdata, checksum}, 64'd0);
      rst = 1'b0;
      tick();
      check("post_rst_idle", 64'(status()), 64'(S_IDLE));
      start = 1'b1; tick(); start = 1'b0;
      send_word(32'hE3A01005, 1'b1, 8'd0);
      tick();
      check("post_rst_done", 64'(status()), 64'(S_DONE));
      tick();
      check("post_rst_idle2", 64'(status()), 64'(S_IDLE));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
